// File: rtl/vc_arbiter_ctrl.sv
// Arbiter between the VC0/VC1 source FIFOs and the D0/D1 destination FIFOs. VC0 has fixed priority.
// Pops are combinational; the popped word appears on data_out/push_dX one cycle later.
module vc_arbiter_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_vc0_in,
  input  logic [3:0]            umbral_vc1_in,
  input  logic [3:0]            umbral_d_in,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_head,
  input  logic [DATA_WIDTH-1:0] vc1_head,
  input  logic                  d0_full,
  input  logic                  d0_almost_full,
  input  logic                  d1_full,
  input  logic                  d1_almost_full,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            umbral_vc0,
  output logic [3:0]            umbral_vc1,
  output logic [3:0]            umbral_d,
  output logic [CNT_WIDTH-1:0]  cnt_d0,
  output logic [CNT_WIDTH-1:0]  cnt_d1,
  output logic                  idle,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_push_d0;
  logic                  r_push_d1;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_umbral_vc0;
  logic [3:0]            r_umbral_vc1;
  logic [3:0]            r_umbral_d;
  logic [CNT_WIDTH-1:0]  r_cnt_d0;
  logic [CNT_WIDTH-1:0]  r_cnt_d1;
  logic                  r_idle;

  logic                  w_blk0;
  logic                  w_blk1;
  logic                  w_el0;
  logic                  w_el1;
  logic                  w_pop0;
  logic                  w_pop1;
  logic                  w_pop_any;
  logic [DATA_WIDTH-1:0] w_word;

  // almost_full alone blocks, keeping one slot of margin for the registered push
  assign w_blk0 = vc0_head[DATA_WIDTH-1] ? (d1_full | d1_almost_full) : (d0_full | d0_almost_full);
  assign w_blk1 = vc1_head[DATA_WIDTH-1] ? (d1_full | d1_almost_full) : (d0_full | d0_almost_full);
  assign w_el0  = !vc0_empty && !w_blk0;
  assign w_el1  = !vc1_empty && !w_blk1;

  always_comb begin
    w_next = r_state;
    w_pop0 = 1'b0;
    w_pop1 = 1'b0;
    case (r_state)
      S_RESET:  w_next = S_INIT;
      S_INIT:   w_next = init ? S_INIT : S_IDLE;
      S_IDLE:   w_next = (!vc0_empty || !vc1_empty) ? S_ACTIVE : S_IDLE;
      S_ACTIVE: begin
        w_next = (vc0_empty && vc1_empty) ? S_IDLE : S_ACTIVE;
        // a blocked VC0 yields to an eligible VC1 (no head-of-line blocking)
        w_pop0 = w_el0;
        w_pop1 = w_el1 && !w_el0;
      end
      default:  w_next = S_RESET;
    endcase
    if (init) begin
      w_next = S_INIT;
    end
  end

  assign w_pop_any = w_pop0 | w_pop1;
  assign w_word    = w_pop0 ? vc0_head : vc1_head;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_RESET;
      r_push_d0    <= 1'b0;
      r_push_d1    <= 1'b0;
      r_data       <= '0;
      r_umbral_vc0 <= '0;
      r_umbral_vc1 <= '0;
      r_umbral_d   <= '0;
      r_cnt_d0     <= '0;
      r_cnt_d1     <= '0;
      r_idle       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_push_d0 <= w_pop_any && !w_word[DATA_WIDTH-1];
      r_push_d1 <= w_pop_any &&  w_word[DATA_WIDTH-1];
      if (w_pop_any) begin
        r_data <= w_word;
        if (w_word[DATA_WIDTH-1]) begin
          r_cnt_d1 <= r_cnt_d1 + CNT_WIDTH'(1);
        end else begin
          r_cnt_d0 <= r_cnt_d0 + CNT_WIDTH'(1);
        end
      end
      if (r_state == S_INIT && init) begin
        r_umbral_vc0 <= umbral_vc0_in;
        r_umbral_vc1 <= umbral_vc1_in;
        r_umbral_d   <= umbral_d_in;
      end
      r_idle <= (w_next == S_IDLE) && vc0_empty && vc1_empty;
    end
  end

  assign pop_vc0    = w_pop0;
  assign pop_vc1    = w_pop1;
  assign push_d0    = r_push_d0;
  assign push_d1    = r_push_d1;
  assign data_out   = r_data;
  assign umbral_vc0 = r_umbral_vc0;
  assign umbral_vc1 = r_umbral_vc1;
  assign umbral_d   = r_umbral_d;
  assign cnt_d0     = r_cnt_d0;
  assign cnt_d1     = r_cnt_d1;
  assign idle       = r_idle;
  assign state      = r_state;

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Directed bench for vc_arbiter_ctrl: VC FIFOs modelled as queues, popped words scoreboarded
// against the registered push/data_out one cycle later.
module tb_vc_arbiter_ctrl;
  localparam int DW = 6;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, init;
  logic [3:0]    umbral_vc0_in, umbral_vc1_in, umbral_d_in;
  logic          vc0_empty, vc1_empty;
  logic [DW-1:0] vc0_head, vc1_head;
  logic          d0_full, d0_almost_full, d1_full, d1_almost_full;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [DW-1:0] data_out;
  logic [3:0]    umbral_vc0, umbral_vc1, umbral_d;
  logic [CW-1:0] cnt_d0, cnt_d1;
  logic [1:0]    state;

  vc_arbiter_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_vc0_in(umbral_vc0_in), .umbral_vc1_in(umbral_vc1_in), .umbral_d_in(umbral_d_in),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty), .vc0_head(vc0_head), .vc1_head(vc1_head),
    .d0_full(d0_full), .d0_almost_full(d0_almost_full),
    .d1_full(d1_full), .d1_almost_full(d1_almost_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .umbral_vc0(umbral_vc0), .umbral_vc1(umbral_vc1), .umbral_d(umbral_d),
    .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle), .state(state)
  );

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  logic [DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  logic [1:0]    m_state = 2'd0;
  logic          m_push0, m_push1, m_idle;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt0, m_cnt1;
  logic [3:0]    m_u0, m_u1, m_ud;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic blk(input logic d);
    return d ? (d1_full | d1_almost_full) : (d0_full | d0_almost_full);
  endfunction

  task automatic drive();
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
    vc0_head  = vc0_empty ? '0 : vc0_q[0];
    vc1_head  = vc1_empty ? '0 : vc1_q[0];
  endtask

  // one clock: check pops, advance model and queues, check registered outputs
  task automatic step(input string tag);
    logic e0, e1, p0, p1, act, v0e, v1e;
    logic [1:0]    nxt;
    logic [DW-1:0] w;
    drive();
    #1;
    v0e = vc0_empty;
    v1e = vc1_empty;
    act = (m_state == 2'd3);
    e0  = !v0e && !blk(vc0_head[DW-1]);
    e1  = !v1e && !blk(vc1_head[DW-1]);
    p0  = act && e0;
    p1  = act && e1 && !e0;
    chk({tag, ":pop"}, 32'({pop_vc0, pop_vc1}), 32'({p0, p1}));
    w = p0 ? vc0_head : vc1_head;
    if ((p0 || p1) && reset) exp_q.push_back(w);
    @(posedge clk);
    if (p0) void'(vc0_q.pop_front());
    if (p1) void'(vc1_q.pop_front());
    if (!reset) begin
      m_state = 2'd0; m_push0 = 1'b0; m_push1 = 1'b0; m_data = '0;
      m_cnt0 = '0; m_cnt1 = '0; m_idle = 1'b0; m_u0 = '0; m_u1 = '0; m_ud = '0;
    end else begin
      case (m_state)
        2'd0:    nxt = 2'd1;
        2'd1:    nxt = init ? 2'd1 : 2'd2;
        2'd2:    nxt = (!v0e || !v1e) ? 2'd3 : 2'd2;
        default: nxt = (v0e && v1e) ? 2'd2 : 2'd3;
      endcase
      if (init) nxt = 2'd1;
      if (m_state == 2'd1 && init) begin
        m_u0 = umbral_vc0_in; m_u1 = umbral_vc1_in; m_ud = umbral_d_in;
      end
      m_push0 = (p0 || p1) && !w[DW-1];
      m_push1 = (p0 || p1) && w[DW-1];
      if (p0 || p1) begin
        m_data = w;
        if (w[DW-1]) m_cnt1 = m_cnt1 + 1'b1;
        else         m_cnt0 = m_cnt0 + 1'b1;
      end
      m_idle  = (nxt == 2'd2) && v0e && v1e;
      m_state = nxt;
    end
    #1;
    chk({tag, ":push"}, 32'({push_d0, push_d1}), 32'({m_push0, m_push1}));
    if (m_push0 || m_push1) chk({tag, ":data"}, 32'(data_out), 32'(exp_q.pop_front()));
    else                    chk({tag, ":hold"}, 32'(data_out), 32'(m_data));
    chk({tag, ":cnt"}, 32'({cnt_d0, cnt_d1}), 32'({m_cnt0, m_cnt1}));
    chk({tag, ":state"}, 32'(state), 32'(m_state));
    chk({tag, ":idle"}, 32'(idle), 32'(m_idle));
    chk({tag, ":umbral"}, 32'({umbral_vc0, umbral_vc1, umbral_d}), 32'({m_u0, m_u1, m_ud}));
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (vc0_q.size() + vc1_q.size()) != 0; i++) step(tag);
    step(tag);
    chk({tag, ":drained"}, 32'(vc0_q.size() + vc1_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; init = 1'b0;
    umbral_vc0_in = 4'd0; umbral_vc1_in = 4'd0; umbral_d_in = 4'd0;
    d0_full = 1'b0; d0_almost_full = 1'b0; d1_full = 1'b0; d1_almost_full = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);

    // 1: reset, then configuration
    step("rst");
    step("rst");
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({push_d0, push_d1, data_out, cnt_d0, cnt_d1, idle}), 32'd0);
    reset = 1'b1; init = 1'b1;
    umbral_vc0_in = 4'd3; umbral_vc1_in = 4'd5; umbral_d_in = 4'd2;
    step("init");
    step("init");
    chk("init_state", 32'(state), 32'd1);
    chk("init_umbral", 32'({umbral_vc0, umbral_vc1, umbral_d}), 32'h352);

    // 2: single word VC0 -> D0
    init = 1'b0;
    step("idle");
    chk("idle_flag", 32'(idle), 32'd1);
    vc0_q.push_back(6'b000101);
    step("act");
    step("pop1");
    chk("t2_push_d0", 32'(push_d0), 32'd1);
    chk("t2_data", 32'(data_out), 32'h05);
    chk("t2_cnt_d0", 32'(cnt_d0), 32'd1);
    drain("t2", 4);

    // 3: VC0 priority over VC1
    vc0_q.push_back(6'b000001); vc0_q.push_back(6'b000010); vc0_q.push_back(6'b000011);
    vc1_q.push_back(6'b000100); vc1_q.push_back(6'b100101);
    drain("prio", 12);

    // 4: blocked VC0 does not stall VC1
    vc0_q.push_back(6'b100011);
    vc1_q.push_back(6'b000111);
    d1_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) step("hol");
    chk("hol_vc0_kept", 32'(vc0_q.size()), 32'd1);
    chk("hol_vc1_sent", 32'(vc1_q.size()), 32'd0);
    d1_almost_full = 1'b0;
    drain("hol", 4);
    chk("t4_cnt_d0", 32'(cnt_d0), 32'd6);

    // 5: counter wrap and both destinations full
    for (int i = 0; i < 32; i++) vc1_q.push_back(6'h20 | 6'(i));
    drain("wrap", 40);
    chk("wrap_cnt_d1", 32'(cnt_d1), 32'd2);
    d0_full = 1'b1; d1_full = 1'b1;
    vc0_q.push_back(6'h01);
    vc1_q.push_back(6'h22);
    for (int i = 0; i < 3; i++) step("full");
    chk("full_state", 32'(state), 32'd3);
    chk("full_kept", 32'(vc0_q.size() + vc1_q.size()), 32'd2);

    // 6: reset while popping drops the word
    d0_full = 1'b0;
    reset = 1'b0;
    step("rstpop");
    chk("rstpop_state", 32'(state), 32'd0);
    chk("rstpop_outs", 32'({push_d0, push_d1, cnt_d0, cnt_d1}), 32'd0);
    reset = 1'b1;
    d1_full = 1'b0;
    drain("post", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
